// File: rtl/dmem_mmio_responder.sv
// Data RAM plus MMIO window (LED, switches, timer) on the CPU data port.
// Define DMEM_TIMER_EN to build the timer registers at offsets 0x08-0x14.
module dmem_mmio_responder #(
  parameter int          DEPTH_WORDS  = 1024,
  parameter logic [15:0] MMIO_BASE_HI = 16'hBFAF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [3:0]  memwrite,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [15:0] sw_in,
  output logic [15:0] led_out,
  output logic        timer_irq
);

  localparam int AW = $clog2(DEPTH_WORDS);

  function automatic logic [31:0] mergeBytes(
    input logic [31:0] oldWord,
    input logic [31:0] newWord,
    input logic [3:0]  be
  );
    logic [31:0] r;
    r = oldWord;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[i*8 +: 8] = newWord[i*8 +: 8];
    return r;
  endfunction

  logic [31:0] ram [DEPTH_WORDS];

  logic          isMmio;
  logic [5:0]    offset;
  logic [AW-1:0] ramIdx;
  logic          anyWr;
  logic          ramWr;
  logic [31:0]   ramMerged;
  logic          unusedAddr;

  assign isMmio     = addr[31:16] == MMIO_BASE_HI;
  assign offset     = addr[7:2];
  assign ramIdx     = addr[AW+1:2];
  assign anyWr      = |memwrite;
  assign ramWr      = !isMmio && anyWr;
  assign ramMerged  = mergeBytes(ram[ramIdx], writedata, memwrite);
  assign unusedAddr = ^addr;

  logic selLed;
  logic selSw;

  assign selLed = isMmio && offset == 6'h00;
  assign selSw  = isMmio && offset == 6'h01;

  logic [15:0] ledReg;
  logic [15:0] ledNext;
  logic [31:0] ledMerged;
  logic [15:0] swSync1;
  logic [15:0] swSync2;

  assign ledMerged = mergeBytes({16'h0, ledReg}, writedata, memwrite);
  assign ledNext   = (selLed && anyWr) ? ledMerged[15:0] : ledReg;
  assign led_out   = ledReg;

`ifdef DMEM_TIMER_EN
  logic        selCnt;
  logic        selCmp;
  logic        selStat;
  logic        selCtrl;
  logic [31:0] count;
  logic [31:0] countNext;
  logic [31:0] cmp;
  logic [31:0] cmpNext;
  logic        flag;
  logic        flagNext;
  logic        en;
  logic        enNext;
  logic        matchHit;
  logic        clrReq;

  assign selCnt  = isMmio && offset == 6'h02;
  assign selCmp  = isMmio && offset == 6'h03;
  assign selStat = isMmio && offset == 6'h04;
  assign selCtrl = isMmio && offset == 6'h05;

  assign matchHit = en && count == cmp;
  assign clrReq   = selStat && memwrite[0] && writedata[0];

  // A CPU write to COUNT takes precedence over the running increment.
  always_comb begin
    countNext = count;
    if (selCnt && anyWr)
      countNext = mergeBytes(count, writedata, memwrite);
    else if (en)
      countNext = count + 32'd1;
  end

  assign cmpNext  = (selCmp && anyWr)
                  ? mergeBytes(cmp, writedata, memwrite) : cmp;
  assign flagNext = matchHit || (flag && !clrReq);
  assign enNext   = (selCtrl && memwrite[0]) ? writedata[0] : en;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      cmp   <= 32'hFFFF_FFFF;
      flag  <= 1'b0;
      en    <= 1'b0;
    end else begin
      count <= countNext;
      cmp   <= cmpNext;
      flag  <= flagNext;
      en    <= enNext;
    end
  end

  assign timer_irq = flag;
`else
  assign timer_irq = 1'b0;
`endif

  // Reads return the post-edge value, so a write shows up immediately.
  logic [31:0] rdNext;

  always_comb begin
    rdNext = '0;
    unique case (1'b1)
      !isMmio: rdNext = ramMerged;
      selLed:  rdNext = {16'h0, ledNext};
      selSw:   rdNext = {16'h0, swSync2};
`ifdef DMEM_TIMER_EN
      selCnt:  rdNext = countNext;
      selCmp:  rdNext = cmpNext;
      selStat: rdNext = {31'h0, flagNext};
      selCtrl: rdNext = {31'h0, enNext};
`endif
      default: rdNext = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      readdata <= '0;
      ledReg   <= '0;
      swSync1  <= '0;
      swSync2  <= '0;
    end else begin
      readdata <= rdNext;
      ledReg   <= ledNext;
      swSync1  <= sw_in;
      swSync2  <= swSync1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && ramWr)
      ram[ramIdx] <= ramMerged;
  end

endmodule

// File: doc/dmem_mmio_responder.md
Name: dmem_mmio_responder

Overview:
- Responder on the CPU data-memory port (address / 4-bit byte-write enable / write data in, read data out).
- Contains a word-organised data RAM and a small memory-mapped peripheral window: LED register, synchronised switch input, and a programmable timer.
- Sits beside the CPU top and is driven directly by its M-stage data signals.
- Read data is registered, so the CPU consumes it in W stage.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit RAM words; power of two; RAM index = addr[log2(DEPTH_WORDS)+1:2].
- MMIO_BASE_HI, 16'hBFAF, value of addr[31:16] that selects the MMIO window instead of RAM.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- addr  in  32  byte address from CPU M stage (aluoutM); addr[1:0] ignored
- memwrite  in  4  byte write enables; bit0 = bits 7:0 … bit3 = bits 31:24
- writedata  in  32  store data, already lane-aligned by CPU
- readdata  out  32  registered read word for the address presented the previous cycle
- sw_in  in  16  asynchronous board switches
- led_out  out  16  LED register contents
- timer_irq  out  1  timer match flag (level)

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - readdata = 0, led_out = 0, timer_irq = 0.
  - Switch synchroniser = 0, TIMER_COUNT = 0, TIMER_CMP = 32'hFFFF_FFFF, TIMER_CTRL = 0.
  - RAM contents are not cleared.
- Decode: MMIO when addr[31:16] == MMIO_BASE_HI; otherwise RAM. RAM index uses low address bits only, so higher bits alias.
- Reads:
  - Every cycle is a read; no read strobe.
  - readdata at edge N+1 = word at addr sampled at edge N (1-cycle latency), full 32 bits; the CPU performs byte/half extraction.
- Writes:
  - Any memwrite bit set writes the enabled byte lanes at edge N; disabled lanes are unchanged.
  - Write-first: a write at edge N also updates readdata at N+1 with the merged word.
- MMIO map (offset = addr[7:2]*4). Unlisted offsets read 0 and ignore writes.
  - 0x00 LED: RW, bits 15:0 only, upper bits read 0; drives led_out.
  - 0x04 SWITCH: RO, two-flop synchronised sw_in, zero-extended; latency 2 cycles from sw_in change to register.
  - 0x08 TIMER_COUNT: RW, byte-enable writes.
  - 0x0C TIMER_CMP: RW, byte-enable writes.
  - 0x10 TIMER_STAT: bit0 = match flag (= timer_irq); write 1 to bit0 (memwrite[0] set) clears it; other bits read 0.
  - 0x14 TIMER_CTRL: bit0 = enable; RW via memwrite[0].
- Timer:
  - When enable = 1, COUNT increments by 1 each cycle and wraps 32'hFFFF_FFFF -> 0.
  - When COUNT == CMP and enable = 1, flag sets on the next edge and stays set until cleared.
  - CPU write to COUNT in the same cycle as an increment: the write wins, with no increment that cycle.
  - Set and W1C clear in the same cycle: set wins.
  - Disabling holds COUNT; flag is unchanged.
- Reset asserted mid-operation: all registers return to reset values on that edge; any write in that cycle is discarded, RAM included.

Optional Feature:
- Macro: DMEM_TIMER_EN.
- Defined: timer registers 0x08–0x14 implemented as above.
- Undefined: those offsets read 0 and ignore writes, timer_irq is tied to 0, and no timer flops are synthesised. LED, SWITCH and RAM are unaffected.

Test Plan:
- RAM word and lane writes:
  - Reset; write 32'hDEADBEEF to 0x00000040 with memwrite = 4'b1111; idle read at 0x40 -> readdata = DEADBEEF exactly one cycle after the address.
  - Then memwrite = 4'b0010 with data 32'h0000AA00 -> read 0x40 = DEADAAEF.
- Write-first and aliasing: with DEPTH_WORDS = 1024, write 32'h12345678 to 0x00001000 -> next-cycle readdata = 12345678; read 0x00000000 -> 12345678 (alias).
- LED/SWITCH:
  - Write 32'hFFFF_A5A5 to 0xBFAF0000 -> led_out = A5A5, readback = 0000A5A5.
  - Set sw_in = 16'h0F0F -> SWITCH read returns 00000F0F no earlier than 2 cycles after the change.
- Timer match (DMEM_TIMER_EN defined):
  - CMP = 5, COUNT = 0, CTRL = 1 -> timer_irq rises on the edge after COUNT reaches 5, and stays high through wrap.
  - Write 1 to STAT -> timer_irq = 0.
  - Clear issued in the same cycle as a new match -> timer_irq stays 1.
- Timer boundaries:
  - COUNT = FFFFFFFE, enable -> reads FFFFFFFF then 0.
  - Write COUNT = 100 in the same cycle as an increment -> next read 100.
  - Assert rst mid-count -> COUNT = 0, CMP = FFFFFFFF, led_out = 0, readdata = 0.
- Macro off: build without DMEM_TIMER_EN; write CTRL = 1 and CMP = 0 -> offsets 0x08–0x14 read 0, and timer_irq stays 0 for 100 cycles.
